// File: rtl/text_term_pkg.sv
// Shared constants, state encoding and small helpers for the text terminal.
package text_term_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    SCROLL
  } state_t;

  // Codes that occupy a cell when received (space through tilde).
  function automatic logic is_printable(input logic [7:0] code);
    return (code >= ASCII_SPACE) && (code <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_term_font_rom.sv
// 4096x8 glyph ROM addressed by {code, line}, asynchronous read.
// Glyphs are generated from the address: every printable code except space
// draws a framed box whose inner lines show the 7-bit code as a pixel
// pattern; space and all control codes are blank.
module font_rom
  import text_term_pkg::*;
(
  input  logic [11:0] addr,
  output logic [7:0]  data
);

  logic [7:0] code;
  logic [3:0] line;

  assign code = addr[11:4];
  assign line = addr[3:0];

  // Glyph line lookup.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    data = 8'h00;
    if (is_printable(code) && (code != ASCII_SPACE)) begin
      if ((line == 4'd2) || (line == 4'(CHAR_H - 3)))
        data = 8'h7E;
      else if ((line > 4'd2) && (line < 4'(CHAR_H - 3)))
        data = {1'b0, code[6:0]};
    end
  end

endmodule

// File: rtl/text_term.sv
// Character-mode terminal: 80x30 cell buffer fed by a valid/ready ASCII
// stream, rendered combinationally as 8x16 glyphs for the VGA controller.
module text_term #(
  parameter int          COLS      = text_term_pkg::COLS,
  parameter int          ROWS      = text_term_pkg::ROWS,
  parameter logic [11:0] FG        = 12'hFFF,
  parameter logic [11:0] BG        = 12'h000,
  parameter int          BLINK_DIV = 12500000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  output logic [11:0] vga_data,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  import text_term_pkg::*;

  localparam int CELLS   = COLS * ROWS;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Logical row plus scroll offset, wrapped into 0..ROWS-1 without a divider.
  function automatic logic [4:0] add_mod(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ROWS))
      s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [11:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
    return 12'(prow) * 12'(COLS) + 12'(col);
  endfunction

  state_t              state, state_nx;
  logic [11:0]         clr_addr, clr_nx;
  logic [6:0]          scr_cnt, scr_nx;
  logic [4:0]          top_row, top_nx;
  logic [6:0]          x_nx;
  logic [4:0]          y_nx;
  logic                do_nl;
  logic                mem_we;
  logic [11:0]         mem_waddr;
  logic [7:0]          mem_wdata;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_on;

  logic [7:0]          mem [CELLS];

  // State register and cursor/scroll bookkeeping.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state    <= INIT_CLR;
      clr_addr <= '0;
      scr_cnt  <= '0;
      top_row  <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= state_nx;
      clr_addr <= clr_nx;
      scr_cnt  <= scr_nx;
      top_row  <= top_nx;
      cursor_x <= x_nx;
      cursor_y <= y_nx;
    end
  end

  // Next-state, cursor movement, buffer write port and handshake.
  always_comb begin
    state_nx  = state;
    clr_nx    = clr_addr;
    scr_nx    = scr_cnt;
    top_nx    = top_row;
    x_nx      = cursor_x;
    y_nx      = cursor_y;
    do_nl     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cell_addr(add_mod(cursor_y, top_row), cursor_x);
    mem_wdata = ASCII_SPACE;
    ch_ready  = 1'b0;

    unique case (state)
      INIT_CLR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        if (clr_addr == 12'(CELLS - 1)) begin
          clr_nx   = '0;
          state_nx = IDLE;
        end else begin
          clr_nx = clr_addr + 12'd1;
        end
      end

      IDLE: begin
        ch_ready = 1'b1;
        if (ch_valid) begin
          // NOTE: blocking assignments here let do_nl and x_nx/y_nx be reused later in this same pass.
          if (is_printable(ch_data)) begin
            mem_we    = 1'b1;
            mem_wdata = ch_data;
            if (cursor_x == 7'(COLS - 1))
              do_nl = 1'b1;
            else
              x_nx = cursor_x + 7'd1;
          end else if ((ch_data == ASCII_LF) || (ch_data == ASCII_CR)) begin
            do_nl = 1'b1;
          end else if (ch_data == ASCII_BS) begin
            if (cursor_x != '0) begin
              x_nx = cursor_x - 7'd1;
            end else if (cursor_y != '0) begin
              x_nx = 7'(COLS - 1);
              y_nx = cursor_y - 5'd1;
            end
            // The cleared cell is the one the cursor lands on.
            mem_we    = 1'b1;
            mem_waddr = cell_addr(add_mod(y_nx, top_row), x_nx);
          end

          if (do_nl) begin
            x_nx = '0;
            if (cursor_y == 5'(ROWS - 1)) begin
              // Old top row becomes the new bottom row and is blanked in SCROLL.
              top_nx   = add_mod(top_row, 5'd1);
              scr_nx   = '0;
              state_nx = SCROLL;
            end else begin
              y_nx = cursor_y + 5'd1;
            end
          end
        end
      end

      SCROLL: begin
        mem_we    = 1'b1;
        mem_waddr = cell_addr(add_mod(5'(ROWS - 1), top_row), scr_cnt);
        if (scr_cnt == 7'(COLS - 1))
          state_nx = IDLE;
        else
          scr_nx = scr_cnt + 7'd1;
      end

      default: state_nx = INIT_CLR;
    endcase
  end

  // Character buffer write port.
  always_ff @(posedge pclk) begin
    // NOTE: the buffer has no reset; INIT_CLR blanks it after every reset instead.
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // Cursor blink timebase.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Zero-latency render path.
  logic [6:0]  rd_col;
  logic [4:0]  rd_row;
  logic        in_range;
  logic [11:0] rd_addr;
  logic [7:0]  rd_code;
  logic [7:0]  glyph;
  logic        pix;
  logic        underline;

  assign rd_col   = h_addr[9:3];
  assign rd_row   = v_addr[8:4];
  assign in_range = !v_addr[9] && (rd_col < 7'(COLS)) && (rd_row < 5'(ROWS));
  assign rd_addr  = in_range ? cell_addr(add_mod(rd_row, top_row), rd_col) : '0;
  assign rd_code  = mem[rd_addr];

  font_rom u_font (
    .addr ({rd_code, v_addr[3:0]}),
    .data (glyph)
  );

  assign pix       = glyph[3'(CHAR_W - 1) - h_addr[2:0]];
  assign underline = blink_on && (rd_col == cursor_x) && (rd_row == cursor_y)
                     && (v_addr[3:0] >= 4'd14);

  // Final colour mux; blanking and out-of-range areas never show foreground.
  always_comb begin
    if (!valid)
      vga_data = 12'h000;
    else if (in_range && (pix || underline))
      vga_data = FG;
    else
      vga_data = BG;
  end

endmodule

// File: tb/tb_text_term.sv
// Directed bench for text_term: init clear, glyph rendering, cursor blink,
// wrap, backspace, scrolling and reset during scroll.
`timescale 1ns/1ps
module tb_text_term;

  localparam int          TB_BLINK = 1000;
  localparam logic [11:0] FG       = 12'hFFF;

  logic        pclk;
  logic        reset;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        valid;
  logic [11:0] vga_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  int vectors     = 0;
  int miscompares = 0;
  int cyc;

  text_term #(.BLINK_DIV(TB_BLINK)) dut (
    .pclk     (pclk),
    .reset    (reset),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .h_addr   (h_addr),
    .v_addr   (v_addr),
    .valid    (valid),
    .vga_data (vga_data),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y)
  );

  initial pclk = 1'b0;
  always #20 pclk = ~pclk;

  // Clock edges since reset release, used to predict the blink phase.
  always @(posedge pclk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge pclk);
    ch_data  = c;
    ch_valid = 1'b1;
    while (!ch_ready && n < 5000) begin
      @(negedge pclk);
      n++;
    end
    check("send_ready", 32'(ch_ready), 32'd1);
    @(posedge pclk);
    #1;
    ch_valid = 1'b0;
  endtask

  // Counts negedges (starting with the current one) while ch_ready is low.
  task automatic count_low(output int n);
    n = 0;
    while (!ch_ready && n < 5000) begin
      n++;
      @(negedge pclk);
    end
  endtask

  // Reconstructs one glyph line of a cell from the rendered pixels.
  task automatic read_line(input int c, input int r, input int line, output logic [7:0] bits);
    @(negedge pclk);
    for (int p = 0; p < 8; p++) begin
      h_addr = 10'(c * 8 + p);
      v_addr = 10'(r * 16 + line);
      #1;
      bits[7 - p] = (vga_data === FG);
    end
  endtask

  task automatic check_cell(input int c, input int r, input logic [7:0] exp);
    logic [7:0] b;
    read_line(c, r, 3, b);
    check($sformatf("cell_%0d_%0d", c, r), 32'(b), 32'(exp));
  endtask

  task automatic check_pixel(input string tag, input int h, input int v, input logic [11:0] exp);
    h_addr = 10'(h);
    v_addr = 10'(v);
    #1;
    check(tag, 32'(vga_data), 32'(exp));
  endtask

  logic [7:0] a_glyph [16];
  logic [7:0] b;
  int         n;

  initial begin
    a_glyph = '{8'h00, 8'h00, 8'h7E, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41,
                8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h7E, 8'h00, 8'h00};
    reset    = 1'b1;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    h_addr   = '0;
    v_addr   = '0;
    valid    = 1'b1;

    // Reset state.
    repeat (3) @(negedge pclk);
    check("rst_ready", 32'(ch_ready), 32'd0);
    check("rst_cx", 32'(cursor_x), 32'd0);
    check("rst_cy", 32'(cursor_y), 32'd0);

    // Initial clear holds off the stream for exactly 2400 cycles.
    @(negedge pclk);
    reset = 1'b0;
    count_low(n);
    check("init_cycles", 32'(n), 32'd2400);
    check("init_ready", 32'(ch_ready), 32'd1);

    // Whole buffer is blank after the clear.
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        check_cell(c, r, 8'h00);

    // 'A' at the origin: cursor advances, glyph rendered FG on BG.
    send(8'h41);
    check("a_cx", 32'(cursor_x), 32'd1);
    check("a_cy", 32'(cursor_y), 32'd0);
    for (int l = 0; l < 16; l++) begin
      read_line(0, 0, l, b);
      check($sformatf("a_line_%0d", l), 32'(b), 32'(a_glyph[l]));
    end
    @(negedge pclk);
    check_pixel("a_lit", 1, 3, 12'hFFF);
    check_pixel("a_dark", 0, 3, 12'h000);
    valid = 1'b0;
    check_pixel("blank_valid", 1, 3, 12'h000);
    valid = 1'b1;

    // Cursor underline on lines 14..15 of the cursor cell while blink is on.
    while (((cyc / TB_BLINK) % 2) == 0) @(negedge pclk);
    check_pixel("ul_on_15", 8 + 3, 15, 12'hFFF);
    check_pixel("ul_on_14", 8 + 3, 14, 12'hFFF);
    check_pixel("ul_on_13", 8 + 3, 13, 12'h000);
    check_pixel("ul_other_cell", 3, 15, 12'h000);
    while (((cyc / TB_BLINK) % 2) == 1) @(negedge pclk);
    check_pixel("ul_off_15", 8 + 3, 15, 12'h000);

    // Backspace from (1,0) then at the origin.
    send(8'h08);
    check("bs1_cx", 32'(cursor_x), 32'd0);
    check("bs1_cy", 32'(cursor_y), 32'd0);
    check_cell(0, 0, 8'h00);
    send(8'h08);
    check("bs0_cx", 32'(cursor_x), 32'd0);
    check("bs0_cy", 32'(cursor_y), 32'd0);
    check_cell(0, 0, 8'h00);

    // Eighty printable codes fill row 0 and wrap to row 1.
    for (int i = 0; i < 80; i++) send(8'(8'h21 + i));
    check("wrap_cx", 32'(cursor_x), 32'd0);
    check("wrap_cy", 32'(cursor_y), 32'd1);
    check_cell(0, 0, 8'h21);
    check_cell(40, 0, 8'h49);
    check_cell(79, 0, 8'h70);

    // Unsupported control code is consumed without effect.
    send(8'h01);
    check("drop_cx", 32'(cursor_x), 32'd0);
    check("drop_cy", 32'(cursor_y), 32'd1);

    // Backspace at column 0 moves to the end of the previous row.
    send(8'h08);
    check("bsrow_cx", 32'(cursor_x), 32'd79);
    check("bsrow_cy", 32'(cursor_y), 32'd0);
    check_cell(79, 0, 8'h00);
    check_cell(78, 0, 8'h6F);

    // CR, then mark rows 1..28 and move down to (5,29).
    send(8'h0D);
    check("cr_cx", 32'(cursor_x), 32'd0);
    check("cr_cy", 32'(cursor_y), 32'd1);
    for (int r = 1; r < 29; r++) begin
      send(8'(8'h40 + r));
      send(8'h0A);
    end
    for (int i = 0; i < 5; i++) send(8'h7A);
    check("pre_cx", 32'(cursor_x), 32'd5);
    check("pre_cy", 32'(cursor_y), 32'd29);

    // Newline on the last row scrolls: 80 blocked cycles.
    send(8'h0A);
    @(negedge pclk);
    count_low(n);
    check("scroll_cycles", 32'(n), 32'd80);
    check("scroll_cx", 32'(cursor_x), 32'd0);
    check("scroll_cy", 32'(cursor_y), 32'd29);
    check_cell(0, 0, 8'h41);
    check_cell(0, 1, 8'h42);
    check_cell(0, 27, 8'h5C);
    check_cell(0, 28, 8'h7A);
    check_cell(4, 28, 8'h7A);
    check_cell(5, 28, 8'h00);
    for (int c = 0; c < 80; c++) check_cell(c, 29, 8'h00);

    // Columns and rows beyond the grid render background.
    @(negedge pclk);
    check_pixel("oor_ref", 1, 19, 12'hFFF);
    check_pixel("oor_col", 641, 3, 12'h000);
    check_pixel("oor_row", 1, 483, 12'h000);

    // Reset in the middle of a second scroll.
    send(8'h0A);
    repeat (40) @(negedge pclk);
    check("mid_scroll_ready", 32'(ch_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ch_ready), 32'd0);
    check("midrst_cx", 32'(cursor_x), 32'd0);
    check("midrst_cy", 32'(cursor_y), 32'd0);
    check("midrst_top", 32'(dut.top_row), 32'd0);
    @(negedge pclk);
    reset = 1'b0;
    count_low(n);
    check("reinit_cycles", 32'(n), 32'd2400);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        check_cell(c, r, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
